// File: rtl/io_decoder_ws_if.sv
// Bus bundle between the Mini8086 I/O bus and the chip-select decoder.
// The master side drives address, strobes and config; the decoder returns CS/READY/ERR.
interface io_decoder_ws_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int WS_W   = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [ADDR_W-1:0] addr;
    logic              wr_n;
    logic              rd_n;
    logic              m_io;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [WS_W-1:0]   cfg_ws;
    logic [NUM_CH-1:0] cs;
    logic              ready;
    logic              err;

    modport master (
        output addr, wr_n, rd_n, m_io, cfg_we, cfg_ch, cfg_ws,
        input  cs, ready, err
    );

    modport slave (
        input  addr, wr_n, rd_n, m_io, cfg_we, cfg_ch, cfg_ws,
        output cs, ready, err
    );
endinterface

// File: rtl/io_decoder_ws.sv
// I/O chip-select decoder with per-channel programmable wait states.
// Strobes are synchronized; CS, READY and ERR all come straight from flops.
module io_decoder_ws #(
    parameter int                       NUM_CH     = 4,
    parameter int                       ADDR_W     = 8,
    parameter int                       WS_W       = 4,
    parameter logic [NUM_CH*ADDR_W-1:0] BASE_ADDRS = {8'h12, 8'h10, 8'h0E, 8'h0C},
    parameter int                       DEFAULT_WS = 1
) (
    input  logic           clk,
    input  logic           rst,
    io_decoder_ws_if.slave bus
);
    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [WS_W-1:0] WS_RST   = WS_W'(DEFAULT_WS);
    localparam logic [WS_W-1:0] WS_ONE   = WS_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] cs_q, cs_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    logic [WS_W-1:0]   ws_q [NUM_CH];

    // Bit order {m_io, wr_n, rd_n}; idle level of all three is high.
    logic [2:0]        sync1_q, sync2_q;
    logic              stb;
    logic              access;
    logic              hit;
    logic [CH_W-1:0]   hit_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {bus.m_io, bus.wr_n, bus.rd_n};
            sync2_q <= sync1_q;
        end
    end

    assign stb    = ~sync2_q[0] | ~sync2_q[1];
    assign access = stb & ~sync2_q[2];

    // Address is used raw: the bus guarantees it settles before the strobe.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!hit && (bus.addr == BASE_ADDRS[i*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ws_q[i] <= WS_RST;
            end
        end else if (bus.cfg_we && ({1'b0, bus.cfg_ch} < NUM_CH_L)) begin
            ws_q[bus.cfg_ch] <= bus.cfg_ws;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cs_q    <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        ready_d = ready_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                cs_d    = '0;
                ready_d = 1'b1;
                if (access) begin
                    if (hit) begin
                        cs_d[hit_idx] = 1'b1;
                        cnt_d         = ws_q[hit_idx];
                        if (ws_q[hit_idx] != '0) begin
                            ready_d = 1'b0;
                            state_d = WAIT;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!stb) begin
                    cs_d    = '0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - WS_ONE;
                    if (cnt_q == WS_ONE) begin
                        ready_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                ready_d = 1'b1;
                if (!stb) begin
                    cs_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                cs_d    = '0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cs    = cs_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_io_decoder_ws.sv
// Directed bench for io_decoder_ws: a vector table of single accesses plus
// hand-written sequences for mid-cycle config, abort, reset and channel priority.
module tb_io_decoder_ws;
    typedef struct {
        logic [7:0] addr;
        logic       rd;
        logic       wr;
        logic       mio;
        logic       doCfg;
        logic [1:0] cfgCh;
        logic [3:0] cfgWs;
        logic [3:0] expCs;
        logic       expErr;
        int         expWs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic       rdN, wrN, mIo;
    logic       cfgWeMain, cfgWe3;
    logic [1:0] cfgCh;
    logic [3:0] cfgWs;
    int         total = 0;
    int         bad = 0;
    vec_t       vecs [8];

    always #5 clk = ~clk;

    io_decoder_ws_if #(.NUM_CH(4), .ADDR_W(8), .WS_W(4)) busA ();
    io_decoder_ws_if #(.NUM_CH(2), .ADDR_W(8), .WS_W(4)) bus2 ();
    io_decoder_ws_if #(.NUM_CH(3), .ADDR_W(8), .WS_W(4)) bus3 ();

    io_decoder_ws #(
        .NUM_CH(4), .ADDR_W(8), .WS_W(4),
        .BASE_ADDRS({8'h12, 8'h10, 8'h0E, 8'h0C}), .DEFAULT_WS(1)
    ) dutA (.clk(clk), .rst(rst), .bus(busA));

    io_decoder_ws #(
        .NUM_CH(2), .ADDR_W(8), .WS_W(4),
        .BASE_ADDRS({8'h20, 8'h20}), .DEFAULT_WS(1)
    ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    io_decoder_ws #(
        .NUM_CH(3), .ADDR_W(8), .WS_W(4),
        .BASE_ADDRS({8'h24, 8'h20, 8'h20}), .DEFAULT_WS(1)
    ) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign busA.addr   = addr;
    assign busA.rd_n   = rdN;
    assign busA.wr_n   = wrN;
    assign busA.m_io   = mIo;
    assign busA.cfg_we = cfgWeMain;
    assign busA.cfg_ch = cfgCh;
    assign busA.cfg_ws = cfgWs;

    assign bus2.addr   = addr;
    assign bus2.rd_n   = rdN;
    assign bus2.wr_n   = wrN;
    assign bus2.m_io   = mIo;
    assign bus2.cfg_we = 1'b0;
    assign bus2.cfg_ch = 1'b0;
    assign bus2.cfg_ws = 4'd0;

    assign bus3.addr   = addr;
    assign bus3.rd_n   = rdN;
    assign bus3.wr_n   = wrN;
    assign bus3.m_io   = mIo;
    assign bus3.cfg_we = cfgWe3;
    assign bus3.cfg_ch = cfgCh;
    assign bus3.cfg_ws = cfgWs;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkMain(input string name, input logic [3:0] expCs, input logic expReady, input logic expErr);
        checkOutput(name, {26'd0, busA.cs, busA.ready, busA.err}, {26'd0, expCs, expReady, expErr});
    endtask

    task automatic pulseCfgMain(input logic [1:0] ch, input logic [3:0] ws);
        cfgWeMain = 1'b1;
        cfgCh     = ch;
        cfgWs     = ws;
        tick(1);
        cfgWeMain = 1'b0;
    endtask

    // One complete access: strobe, CS 3 edges later, READY low expWs cycles, release.
    task automatic applyStimulus(input int idx, input vec_t v);
        if (v.doCfg) pulseCfgMain(v.cfgCh, v.cfgWs);
        addr = v.addr;
        mIo  = v.mio;
        tick(2);
        rdN = ~v.rd;
        wrN = ~v.wr;
        tick(2);
        checkMain($sformatf("v%0d_pre", idx), 4'b0000, 1'b1, 1'b0);
        tick(1);
        checkMain($sformatf("v%0d_start", idx), v.expCs, (v.expWs == 0), v.expErr);
        for (int k = 1; k < v.expWs; k++) begin
            tick(1);
            checkMain($sformatf("v%0d_wait%0d", idx, k), v.expCs, 1'b0, 1'b0);
        end
        tick(1);
        checkMain($sformatf("v%0d_hold", idx), v.expCs, 1'b1, 1'b0);
        rdN = 1'b1;
        wrN = 1'b1;
        tick(2);
        checkMain($sformatf("v%0d_relHeld", idx), v.expCs, 1'b1, 1'b0);
        tick(1);
        checkMain($sformatf("v%0d_relDone", idx), 4'b0000, 1'b1, 1'b0);
        tick(1);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; addr = 8'h00; rdN = 1'b1; wrN = 1'b1; mIo = 1'b0;
        cfgWeMain = 1'b0; cfgWe3 = 1'b0; cfgCh = 2'd0; cfgWs = 4'd0;

        //          addr   rd    wr    mio   cfg   ch     ws     cs        err   ws
        vecs[0] = '{8'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0001, 1'b0, 1};
        vecs[1] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'b1000, 1'b0, 1};
        vecs[2] = '{8'h0E, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0010, 1'b0, 1};
        vecs[3] = '{8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 0};
        vecs[4] = '{8'h0E, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'b0000, 1'b0, 0};
        vecs[5] = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0100, 1'b0, 1};
        vecs[6] = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 4'd5, 4'b0100, 1'b0, 5};
        vecs[7] = '{8'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd0, 4'b0001, 1'b0, 0};

        tick(2);
        checkMain("reset", 4'b0000, 1'b1, 1'b0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

        $display("[TB] mid-cycle config write to channel 2");
        addr = 8'h10; mIo = 1'b0;
        tick(2);
        wrN = 1'b0;
        tick(3);
        checkMain("midcfg_start", 4'b0100, 1'b0, 1'b0);
        pulseCfgMain(2'd2, 4'd0);
        checkMain("midcfg_w1", 4'b0100, 1'b0, 1'b0);
        for (int k = 2; k < 5; k++) begin
            tick(1);
            checkMain($sformatf("midcfg_w%0d", k), 4'b0100, 1'b0, 1'b0);
        end
        tick(1);
        checkMain("midcfg_hold", 4'b0100, 1'b1, 1'b0);
        wrN = 1'b1;
        tick(3);
        checkMain("midcfg_rel", 4'b0000, 1'b1, 1'b0);
        tick(1);
        v = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0100, 1'b0, 0};
        applyStimulus(10, v);

        $display("[TB] aborted wait cycle on channel 3");
        pulseCfgMain(2'd3, 4'd7);
        addr = 8'h12;
        tick(2);
        rdN = 1'b0;
        tick(3);
        checkMain("abort_start", 4'b1000, 1'b0, 1'b0);
        tick(2);
        checkMain("abort_wait2", 4'b1000, 1'b0, 1'b0);
        rdN = 1'b1;
        tick(2);
        checkMain("abort_pending", 4'b1000, 1'b0, 1'b0);
        tick(1);
        checkMain("abort_done", 4'b0000, 1'b1, 1'b0);
        tick(1);
        checkMain("abort_idle", 4'b0000, 1'b1, 1'b0);

        $display("[TB] reset during wait");
        rdN = 1'b0;
        tick(3);
        checkMain("rstwait_start", 4'b1000, 1'b0, 1'b0);
        tick(2);
        rst = 1'b1;
        rdN = 1'b1;
        #1;
        checkMain("rstwait_async", 4'b0000, 1'b1, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(2);
        v = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'b1000, 1'b0, 1};
        applyStimulus(20, v);
        v = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'b0100, 1'b0, 1};
        applyStimulus(21, v);

        $display("[TB] overlapping bases, lowest channel wins");
        addr = 8'h20;
        tick(2);
        rdN = 1'b0;
        tick(3);
        checkOutput("prio_cs2", {30'd0, bus2.cs}, 32'd1);
        checkOutput("prio_cs3", {29'd0, bus3.cs}, 32'd1);
        checkMain("prio_mainMiss", 4'b0000, 1'b1, 1'b1);
        rdN = 1'b1;
        tick(3);
        checkOutput("prio_rel2", {30'd0, bus2.cs}, 32'd0);
        tick(1);

        $display("[TB] out-of-range config channel");
        cfgWe3 = 1'b1; cfgCh = 2'd3; cfgWs = 4'd0;
        tick(1);
        cfgWe3 = 1'b0;
        addr = 8'h24;
        tick(2);
        rdN = 1'b0;
        tick(3);
        checkOutput("oor_cs3", {28'd0, bus3.cs, bus3.ready}, {28'd0, 3'b100, 1'b0});
        rdN = 1'b1;
        tick(4);
        checkOutput("oor_rel3", {28'd0, bus3.cs, bus3.ready}, {28'd0, 3'b000, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
